// File: rtl/kgp_lsu_pkg.sv
// kgp_lsu_pkg
// Shared definitions for the load/store unit:
//   op_e           request opcodes (2-bit encoding seen on req_op)
//   state_e        FSM state encodings
//   LSU_MEM_WORDS  default number of legal data-memory words
package kgp_lsu_pkg;

    typedef enum logic [1:0] {
        OP_LW = 2'b00,
        OP_SW = 2'b01,
        OP_LB = 2'b10,
        OP_SB = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RD   = 2'b01,
        ST_WR   = 2'b10,
        ST_RESP = 2'b11
    } state_e;

    localparam int LSU_MEM_WORDS = 32;

endpackage

// File: rtl/lsu_byte_lane.sv
// lsu_byte_lane
// Combinational little-endian byte-lane helper.
// Ports:
//   rd_word_i  word read from memory (source of the LB extract)
//   mg_word_i  word the SB byte is merged into
//   lane_i     byte lane k (bits [8k+7:8k])
//   byte_i     byte to insert into lane k
//   load_o     lane k of rd_word_i, sign-extended to SIZE bits
//   merged_o   mg_word_i with lane k replaced by byte_i
module lsu_byte_lane #(
    parameter int SIZE = 32
) (
    input  logic [SIZE-1:0] rd_word_i,
    input  logic [SIZE-1:0] mg_word_i,
    input  logic [1:0]      lane_i,
    input  logic [7:0]      byte_i,
    output logic [SIZE-1:0] load_o,
    output logic [SIZE-1:0] merged_o
);

    logic [7:0] sel_byte;

    always_comb begin
        sel_byte = rd_word_i[{lane_i, 3'b000} +: 8];
        load_o   = {{(SIZE-8){sel_byte[7]}}, sel_byte};
        merged_o = mg_word_i;
        merged_o[{lane_i, 3'b000} +: 8] = byte_i;
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
// Single-outstanding load/store unit between a valid/ready request port,
// a valid/ready response port and a word-addressed data memory with
// combinational read data. Supports LW, SW, LB (sign-extended) and SB
// (read-modify-write). Misaligned word accesses and out-of-range words
// return resp_err without touching memory.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        request handshake
//   req_op/req_addr/req_wdata  opcode, byte address, store data
//   resp_valid/resp_ready      response handshake
//   resp_data/resp_err         load result / error flag
//   mem_address                word index (req_addr >> 2)
//   mem_read/mem_write         one-cycle memory strobes
//   mem_write_data             word to store
//   mem_read_data              combinational read data for mem_address
module load_store_unit
    import kgp_lsu_pkg::*;
#(
    parameter int SIZE      = 32,
    parameter int MEM_WORDS = LSU_MEM_WORDS
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [1:0]      req_op,
    input  logic [SIZE-1:0] req_addr,
    input  logic [SIZE-1:0] req_wdata,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [SIZE-1:0] resp_data,
    output logic            resp_err,
    output logic [SIZE-1:0] mem_address,
    output logic            mem_read,
    output logic            mem_write,
    output logic [SIZE-1:0] mem_write_data,
    input  logic [SIZE-1:0] mem_read_data
);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [SIZE-1:0] addr_q, addr_d;
    logic [SIZE-1:0] wdata_q, wdata_d;
    logic [SIZE-1:0] word_q, word_d;
    logic [SIZE-1:0] resp_data_q, resp_data_d;
    logic            resp_err_q, resp_err_d;

    logic [SIZE-1:0] load_ext;
    logic [SIZE-1:0] merged;
    logic            req_err;
    op_e             req_op_e;

    lsu_byte_lane #(.SIZE(SIZE)) u_byte_lane (
        .rd_word_i (mem_read_data),
        .mg_word_i (word_q),
        .lane_i    (addr_q[1:0]),
        .byte_i    (wdata_q[7:0]),
        .load_o    (load_ext),
        .merged_o  (merged)
    );

    assign req_op_e = op_e'(req_op);
    assign req_err  = (((req_op_e == OP_LW) || (req_op_e == OP_SW)) && (req_addr[1:0] != 2'b00))
                    || ((req_addr >> 2) >= SIZE'(MEM_WORDS));

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        word_d      = word_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;

        req_ready      = 1'b0;
        resp_valid     = 1'b0;
        resp_data      = '0;
        resp_err       = 1'b0;
        mem_address    = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_write_data = '0;

        case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    op_d        = req_op_e;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    resp_data_d = '0;
                    resp_err_d  = req_err;
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (req_op_e == OP_SW) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                mem_read    = 1'b1;
                mem_address = addr_q >> 2;
                word_d      = mem_read_data;
                case (op_q)
                    OP_LW: begin
                        resp_data_d = mem_read_data;
                        state_d     = ST_RESP;
                    end
                    OP_LB: begin
                        resp_data_d = load_ext;
                        state_d     = ST_RESP;
                    end
                    default: state_d = ST_WR;
                endcase
            end
            ST_WR: begin
                mem_write      = 1'b1;
                mem_address    = addr_q >> 2;
                mem_write_data = (op_q == OP_SB) ? merged : wdata_q;
                state_d        = ST_RESP;
            end
            ST_RESP: begin
                resp_valid = 1'b1;
                resp_data  = resp_data_q;
                resp_err   = resp_err_q;
                if (resp_ready) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset masks every output immediately so an aborted RD/WR never
        // strobes memory while the state register waits for the edge.
        if (reset) begin
            req_ready      = 1'b0;
            resp_valid     = 1'b0;
            resp_data      = '0;
            resp_err       = 1'b0;
            mem_address    = '0;
            mem_read       = 1'b0;
            mem_write      = 1'b0;
            mem_write_data = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_LW;
            addr_q      <= '0;
            wdata_q     <= '0;
            word_q      <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            word_q      <= word_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
// Self-checking bench for load_store_unit: directed scenarios plus random
// requests compared against a word-array reference model.
module tb_load_store_unit;

    localparam int SIZE      = 32;
    localparam int MEM_WORDS = 32;

    logic            clk;
    logic            reset;
    logic            req_valid;
    logic            req_ready;
    logic [1:0]      req_op;
    logic [SIZE-1:0] req_addr;
    logic [SIZE-1:0] req_wdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [SIZE-1:0] resp_data;
    logic            resp_err;
    logic [SIZE-1:0] mem_address;
    logic            mem_read;
    logic            mem_write;
    logic [SIZE-1:0] mem_write_data;
    logic [SIZE-1:0] mem_read_data;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic        mem_clr;

    load_store_unit #(.SIZE(SIZE), .MEM_WORDS(MEM_WORDS)) dut (
        .clk            (clk),
        .reset          (reset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_data      (resp_data),
        .resp_err       (resp_err),
        .mem_address    (mem_address),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_read_data = (mem_address < MEM_WORDS) ? mem[mem_address[4:0]] : '0;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
        end else if (mem_write && (mem_address < MEM_WORDS)) begin
            mem[mem_address[4:0]] <= mem_write_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: word array plus byte arithmetic.
    task automatic model(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] data, output logic err, output int lat,
                         output int nrd, output int nwr, output logic [31:0] wr_word);
        int unsigned w;
        int unsigned k;
        logic [31:0] b;
        w = addr / 4;
        k = addr % 4;
        data = 0; lat = 2; nrd = 0; nwr = 0; wr_word = 0;
        err = (((op == 2'd0) || (op == 2'd1)) && (k != 0)) || (w >= MEM_WORDS);
        if (err) begin
            lat = 1;
        end else begin
            case (op)
                2'd0: begin data = ref_mem[w]; nrd = 1; end
                2'd1: begin ref_mem[w] = wdata; wr_word = wdata; nwr = 1; end
                2'd2: begin
                    b = (ref_mem[w] >> (8 * k)) & 32'hFF;
                    data = (b >= 128) ? b - 32'd256 : b;
                    nrd = 1;
                end
                default: begin
                    wr_word = (ref_mem[w] & ~(32'hFF << (8 * k))) | ((wdata & 32'hFF) << (8 * k));
                    ref_mem[w] = wr_word;
                    lat = 3; nrd = 1; nwr = 1;
                end
            endcase
        end
    endtask

    // Issue one request, check the response, hold it for 'hold' cycles, then accept it.
    task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                          input int hold, output logic [31:0] got);
        logic [31:0] e_data, e_wr, held;
        logic        e_err;
        int          e_lat, e_rd, e_wr_n, lat, nrd, nwr, guard;
        got = 0;
        @(negedge clk);
        guard = 0;
        while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
        check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        if (!req_ready) return;
        model(op, addr, wdata, e_data, e_err, e_lat, e_rd, e_wr_n, e_wr);
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0; req_op = 2'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 0; nrd = 0; nwr = 0;
        while (lat < 8) begin
            @(negedge clk);
            lat++;
            if (resp_valid) break;
            check("rdwr_excl", {31'd0, mem_read & mem_write}, 32'd0);
            if (mem_read) begin nrd++; check("rd_addr", mem_address, addr >> 2); end
            if (mem_write) begin
                nwr++;
                check("wr_addr", mem_address, addr >> 2);
                check("wr_data", mem_write_data, e_wr);
            end
        end
        check("resp_valid", {31'd0, resp_valid}, 32'd1);
        check("latency", 32'(lat), 32'(e_lat));
        check("resp_data", resp_data, e_data);
        check("resp_err", {31'd0, resp_err}, {31'd0, e_err});
        check("n_reads", 32'(nrd), 32'(e_rd));
        check("n_writes", 32'(nwr), 32'(e_wr_n));
        check("resp_mem_addr", mem_address, 32'd0);
        got = resp_data;
        held = resp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, resp_valid}, 32'd1);
            check("hold_data", resp_data, held);
            check("hold_err", {31'd0, resp_err}, {31'd0, e_err});
            check("hold_ready", {31'd0, req_ready}, 32'd0);
            check("hold_strobes", {30'd0, mem_read, mem_write}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        check("post_valid", {31'd0, resp_valid}, 32'd0);
        check("post_ready", {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int wr_seen;
        reset = 1'b1; mem_clr = 1'b1;
        req_valid = 1'b0; req_op = 2'd0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = '0;
        repeat (3) begin
            @(negedge clk);
            check("rst_outputs", {req_ready, resp_valid, resp_err, mem_read, mem_write},  32'd0);
            check("rst_data", resp_data | mem_address | mem_write_data, 32'd0);
        end
        mem_clr = 1'b0; reset = 1'b0;
        #1 check("rst_release_ready", {31'd0, req_ready}, 32'd1);

        // Preload and directed scenarios
        do_req(2'd1, 32'd8, 32'd1023, 0, d);
        do_req(2'd1, 32'd4, 32'd23, 0, d);
        do_req(2'd0, 32'd8, 32'd0, 0, d);
        check("lw8", d, 32'd1023);
        do_req(2'd3, 32'd5, 32'hAB, 0, d);
        check("sb5_mem", mem[1], 32'h0000AB17);
        do_req(2'd0, 32'd4, 32'd0, 0, d);
        check("lw4", d, 32'h0000AB17);
        do_req(2'd3, 32'd0, 32'h80, 0, d);
        do_req(2'd2, 32'd0, 32'd0, 0, d);
        check("lb0", d, 32'hFFFFFF80);
        do_req(2'd2, 32'd9, 32'd0, 0, d);
        check("lb9", d, 32'h00000003);
        do_req(2'd0, 32'd6, 32'd0, 0, d);
        do_req(2'd1, 32'd128, 32'hDEAD, 0, d);
        do_req(2'd0, 32'd8, 32'd0, 5, d);

        // Reset while an SB sits in RD: no write, response discarded
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd3; req_addr = 32'd12; req_wdata = 32'h5A;
        @(posedge clk);
        #1 req_valid = 1'b0;
        check("abort_in_rd", {31'd0, mem_read}, 32'd1);
        reset = 1'b1;
        #1;
        check("abort_masked", {req_ready, resp_valid, mem_read, mem_write}, 32'd0);
        wr_seen = 0;
        repeat (2) begin @(negedge clk); wr_seen += int'(mem_write); end
        reset = 1'b0;
        #1 check("abort_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        wr_seen += int'(mem_write);
        check("abort_no_write", 32'(wr_seen), 32'd0);
        check("abort_no_resp", {31'd0, resp_valid}, 32'd0);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            do_req(2'($urandom_range(0, 3)), 32'($urandom_range(0, MEM_WORDS * 4 + 15)),
                   $urandom, $urandom_range(0, 2), d);
        end

        @(negedge clk);
        for (int i = 0; i < MEM_WORDS; i++) check("mem_final", mem[i], ref_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
